pim_dma: RTL and testbench

Command-driven DMA engine that serves the core's DMA interface. It accepts a one-cycle command from the EX stage and holds `o_dma_busy` high while it runs, which keeps the core stalled. During that time it moves whole 32-bit words between system memory and a selected PIM macro. It masters memory through a req/gnt port and drives a fixed-latency PIM port.

---
 rtl/dma_pkg.sv | 19 +
 rtl/pim_dma.sv | 162 ++++++++++++++++
 tb/tb_pim_dma.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the PIM DMA engine: command encodings, FSM states
// and fixed widths.
package dma_pkg;

    localparam logic [2:0] DMA_LOAD      = 3'b000;
    localparam logic [2:0] DMA_STORE     = 3'b001;
    localparam int         DMA_CNT_W     = 11;
    localparam logic [3:0] MEM_SIZE_WORD = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        PIM_RD,
        WR_REQ,
        DONE
    } dma_state_e;

endpackage

// File: rtl/pim_dma.sv
// Command-driven DMA engine moving 32-bit words between system memory
// (req/gnt master port) and a selected fixed-latency PIM macro.
module pim_dma
    import dma_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MEM_RD_LAT = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_dma_en,
    input  logic [2:0]           i_dma_funct3,
    input  logic [3:0]           i_dma_sel_pim,
    input  logic [12:0]          i_dma_size,
    input  logic [XLEN-1:0]      i_dma_mem_addr,
    output logic                 o_dma_busy,
    output logic                 o_dma_done,
    output logic                 o_mem_req,
    input  logic                 i_mem_gnt,
    output logic [XLEN-1:0]      o_mem_addr,
    output logic [XLEN-1:0]      o_mem_wdata,
    output logic [3:0]           o_mem_size,
    output logic                 o_mem_read,
    output logic                 o_mem_write,
    input  logic [XLEN-1:0]      i_mem_rdata,
    output logic [3:0]           o_pim_sel,
    output logic                 o_pim_valid,
    output logic                 o_pim_we,
    output logic [DMA_CNT_W-1:0] o_pim_addr,
    output logic [XLEN-1:0]      o_pim_wdata,
    input  logic [XLEN-1:0]      i_pim_rdata
);

    if (MEM_RD_LAT != 1) begin : g_bad_lat
        $error("pim_dma supports MEM_RD_LAT == 1 only");
    end

    dma_state_e           state;
    dma_state_e           next;
    logic [3:0]           sel_q;
    logic [XLEN-1:0]      base_q;
    logic [DMA_CNT_W-1:0] cnt_q;
    logic [DMA_CNT_W-1:0] k_q;
    logic [XLEN-1:0]      data_q;
    logic                 wr_first_q;

    logic                 legal_cmd;
    logic                 accept;
    logic                 last_word;
    logic [DMA_CNT_W-1:0] cmd_cnt;
    logic [XLEN-1:0]      word_addr;
    logic                 unused_bits;

    assign legal_cmd   = (i_dma_funct3 == DMA_LOAD) || (i_dma_funct3 == DMA_STORE);
    assign accept      = (state == IDLE) && i_dma_en && legal_cmd;
    assign cmd_cnt     = i_dma_size[12:2];
    assign last_word   = (k_q == (cnt_q - 11'd1));
    assign word_addr   = base_q + {{(XLEN-DMA_CNT_W-2){1'b0}}, k_q, 2'b00};
    assign unused_bits = ^{i_dma_size[1:0], i_dma_mem_addr[1:0]};

    assign o_dma_busy = (state != IDLE);
    assign o_mem_size = MEM_SIZE_WORD;
    assign o_pim_sel  = (state != IDLE) ? sel_q : 4'd0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    // PIM read data arrives only in the first WR_REQ cycle; later wait cycles use the captured copy.
    always_comb begin
        next        = state;
        o_dma_done  = 1'b0;
        o_mem_req   = 1'b0;
        o_mem_read  = 1'b0;
        o_mem_write = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_pim_valid = 1'b0;
        o_pim_we    = 1'b0;
        o_pim_addr  = '0;
        o_pim_wdata = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_cnt == '0) begin
                        next = DONE;
                    end else if (i_dma_funct3 == DMA_LOAD) begin
                        next = RD_REQ;
                    end else begin
                        next = PIM_RD;
                    end
                end
            end
            RD_REQ: begin
                o_mem_req  = 1'b1;
                o_mem_read = 1'b1;
                o_mem_addr = word_addr;
                if (i_mem_gnt) begin
                    next = RD_DATA;
                end
            end
            RD_DATA: begin
                o_pim_valid = 1'b1;
                o_pim_we    = 1'b1;
                o_pim_addr  = k_q;
                o_pim_wdata = i_mem_rdata;
                next        = last_word ? DONE : RD_REQ;
            end
            PIM_RD: begin
                o_pim_valid = 1'b1;
                o_pim_addr  = k_q;
                next        = WR_REQ;
            end
            WR_REQ: begin
                o_mem_req   = 1'b1;
                o_mem_write = 1'b1;
                o_mem_addr  = word_addr;
                o_mem_wdata = wr_first_q ? i_pim_rdata : data_q;
                if (i_mem_gnt) begin
                    next = last_word ? DONE : PIM_RD;
                end
            end
            DONE: begin
                o_dma_done = 1'b1;
                next       = IDLE;
            end
            default: begin
                next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sel_q      <= '0;
            base_q     <= '0;
            cnt_q      <= '0;
            k_q        <= '0;
            data_q     <= '0;
            wr_first_q <= 1'b0;
        end else begin
            if (accept) begin
                sel_q  <= i_dma_sel_pim;
                base_q <= {i_dma_mem_addr[XLEN-1:2], 2'b00};
                cnt_q  <= cmd_cnt;
                k_q    <= '0;
            end
            wr_first_q <= (state == PIM_RD);
            if ((state == WR_REQ) && wr_first_q) begin
                data_q <= i_pim_rdata;
            end
            if ((state == RD_DATA) || ((state == WR_REQ) && i_mem_gnt)) begin
                k_q <= k_q + 11'd1;
            end
        end
    end

endmodule

// File: tb/tb_pim_dma.sv
// Scoreboard bench for pim_dma: a transaction-level model queues expected
// memory/PIM accesses and busy lengths; a monitor pops and compares them.
module tb_pim_dma;

    localparam int K_MEMRD = 0;
    localparam int K_MEMWR = 1;
    localparam int K_PIMWR = 2;
    localparam int K_PIMRD = 3;
    localparam int K_DONE  = 4;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } ev_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_dma_en;
    logic [2:0]  i_dma_funct3;
    logic [3:0]  i_dma_sel_pim;
    logic [12:0] i_dma_size;
    logic [31:0] i_dma_mem_addr;
    logic        o_dma_busy;
    logic        o_dma_done;
    logic        o_mem_req;
    logic        i_mem_gnt;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_size;
    logic        o_mem_read;
    logic        o_mem_write;
    logic [31:0] i_mem_rdata;
    logic [3:0]  o_pim_sel;
    logic        o_pim_valid;
    logic        o_pim_we;
    logic [10:0] o_pim_addr;
    logic [31:0] o_pim_wdata;
    logic [31:0] i_pim_rdata;

    ev_t  exp_q[$];
    int   wait_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   busy_cnt    = 0;
    int   cur_wait    = -1;
    bit   rd_pending  = 0;
    bit   pim_pending = 0;
    logic [31:0] rd_addr;
    logic [3:0]  pim_rd_sel;
    logic [10:0] pim_rd_addr;
    bit          hold_valid = 0;
    logic [2:0]  hold_ctl;
    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;

    pim_dma #(.XLEN(32), .MEM_RD_LAT(1)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_dma_en       (i_dma_en),
        .i_dma_funct3   (i_dma_funct3),
        .i_dma_sel_pim  (i_dma_sel_pim),
        .i_dma_size     (i_dma_size),
        .i_dma_mem_addr (i_dma_mem_addr),
        .o_dma_busy     (o_dma_busy),
        .o_dma_done     (o_dma_done),
        .o_mem_req      (o_mem_req),
        .i_mem_gnt      (i_mem_gnt),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .o_mem_size     (o_mem_size),
        .o_mem_read     (o_mem_read),
        .o_mem_write    (o_mem_write),
        .i_mem_rdata    (i_mem_rdata),
        .o_pim_sel      (o_pim_sel),
        .o_pim_valid    (o_pim_valid),
        .o_pim_we       (o_pim_we),
        .o_pim_addr     (o_pim_addr),
        .o_pim_wdata    (o_pim_wdata),
        .i_pim_rdata    (i_pim_rdata)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] pim_data(input logic [3:0] s, input logic [10:0] a);
        return 32'hA5A5_0000 + {17'd0, s, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic popCompare(input int kind, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] sel);
        ev_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_event: got kind %0d addr %h, expected none", kind, addr);
            return;
        end
        e = exp_q.pop_front();
        check("event_kind", 32'(kind), 32'(e.kind));
        check("event_addr", addr, e.addr);
        if (e.kind != K_PIMRD) begin
            check("event_data", data, e.data);
        end
        check("event_sel", {28'd0, sel}, {28'd0, e.sel});
    endtask

    // Memory and PIM responders: grant after the planned stall, return data one cycle later.
    always @(posedge i_clk) begin
        #1;
        i_mem_rdata = rd_pending ? mem_data(rd_addr) : $urandom;
        i_pim_rdata = pim_pending ? pim_data(pim_rd_sel, pim_rd_addr) : $urandom;
        rd_pending  = 0;
        pim_pending = 0;
        if (o_mem_req) begin
            if (cur_wait < 0) begin
                cur_wait = (wait_q.size() != 0) ? wait_q.pop_front() : 0;
            end
            if (cur_wait > 0) begin
                i_mem_gnt = 1'b0;
                cur_wait--;
            end else begin
                i_mem_gnt = 1'b1;
                cur_wait  = -1;
            end
        end else begin
            i_mem_gnt = 1'b0;
        end
        if (o_mem_req && i_mem_gnt && o_mem_read) begin
            rd_pending = 1;
            rd_addr    = o_mem_addr;
        end
        if (o_pim_valid && !o_pim_we) begin
            pim_pending = 1;
            pim_rd_sel  = o_pim_sel;
            pim_rd_addr = o_pim_addr;
        end
    end

    // Monitor: every observed transfer is matched against the head of the scoreboard.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_dma_busy) begin
                busy_cnt++;
            end
            if (hold_valid) begin
                check("hold_ctl", {29'd0, o_mem_req, o_mem_read, o_mem_write}, {29'd0, hold_ctl});
                check("hold_addr", o_mem_addr, hold_addr);
                check("hold_wdata", o_mem_wdata, hold_wdata);
                hold_valid = 0;
            end
            if (o_mem_req && !i_mem_gnt) begin
                hold_valid = 1;
                hold_ctl   = {o_mem_req, o_mem_read, o_mem_write};
                hold_addr  = o_mem_addr;
                hold_wdata = o_mem_wdata;
            end
            if (o_mem_req && i_mem_gnt) begin
                check("mem_dir_onehot", {30'd0, o_mem_read, o_mem_write},
                      o_mem_read ? 32'd2 : 32'd1);
                popCompare(o_mem_read ? K_MEMRD : K_MEMWR, o_mem_addr,
                           o_mem_read ? 32'd0 : o_mem_wdata, o_pim_sel);
            end
            if (o_pim_valid) begin
                popCompare(o_pim_we ? K_PIMWR : K_PIMRD, {21'd0, o_pim_addr},
                           o_pim_we ? o_pim_wdata : 32'd0, o_pim_sel);
            end
            if (o_dma_done) begin
                popCompare(K_DONE, 32'd0, 32'(busy_cnt), o_pim_sel);
                busy_cnt = 0;
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] f3, input logic [3:0] sel,
                                 input logic [12:0] size, input logic [31:0] base,
                                 input int stall_word, input int stall_len, input bit rand_stall);
        int          n;
        int          total;
        int          st;
        logic [31:0] b;
        logic [31:0] a;
        n     = int'(size[12:2]);
        b     = {base[31:2], 2'b00};
        total = 0;
        if (f3 == 3'b000 || f3 == 3'b001) begin
            for (int j = 0; j < n; j++) begin
                a  = b + 32'(j) * 32'd4;
                st = (j == stall_word) ? stall_len :
                     (rand_stall && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                total += st;
                wait_q.push_back(st);
                if (f3 == 3'b000) begin
                    exp_q.push_back('{K_MEMRD, a, 32'd0, sel});
                    exp_q.push_back('{K_PIMWR, 32'(j), mem_data(a), sel});
                end else begin
                    exp_q.push_back('{K_PIMRD, 32'(j), 32'd0, sel});
                    exp_q.push_back('{K_MEMWR, a, pim_data(sel, 11'(j)), sel});
                end
            end
            exp_q.push_back('{K_DONE, 32'd0, (n == 0) ? 32'd1 : 32'(2 * n + 1 + total), sel});
        end
        @(posedge i_clk);
        #1;
        i_dma_en       = 1'b1;
        i_dma_funct3   = f3;
        i_dma_sel_pim  = sel;
        i_dma_size     = size;
        i_dma_mem_addr = base;
        @(posedge i_clk);
        #1;
        i_dma_en = 1'b0;
    endtask

    task automatic pulseEnable(input logic [2:0] f3, input logic [12:0] size);
        @(posedge i_clk);
        #1;
        i_dma_en       = 1'b1;
        i_dma_funct3   = f3;
        i_dma_sel_pim  = 4'hF;
        i_dma_size     = size;
        i_dma_mem_addr = 32'h7000_0000;
        @(posedge i_clk);
        #1;
        i_dma_en = 1'b0;
    endtask

    task automatic waitIdle();
        for (int c = 0; c < 5000; c++) begin
            @(negedge i_clk);
            if (!o_dma_busy) begin
                return;
            end
        end
        check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic checkOutput(input string tag);
        check({tag, "_busy"}, {31'd0, o_dma_busy}, 32'd0);
        check({tag, "_done"}, {31'd0, o_dma_done}, 32'd0);
        check({tag, "_req"}, {29'd0, o_mem_req, o_mem_read, o_mem_write}, 32'd0);
        check({tag, "_mem_addr"}, o_mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, o_mem_wdata, 32'd0);
        check({tag, "_pim_ctl"}, {30'd0, o_pim_valid, o_pim_we}, 32'd0);
        check({tag, "_pim_addr"}, {21'd0, o_pim_addr}, 32'd0);
        check({tag, "_pim_wdata"}, o_pim_wdata, 32'd0);
        check({tag, "_pim_sel"}, {28'd0, o_pim_sel}, 32'd0);
    endtask

    initial begin
        bit found;
        i_rst_n        = 1'b0;
        i_dma_en       = 1'b0;
        i_dma_funct3   = 3'b000;
        i_dma_sel_pim  = 4'd0;
        i_dma_size     = 13'd0;
        i_dma_mem_addr = 32'd0;
        i_mem_gnt      = 1'b0;
        i_mem_rdata    = 32'd0;
        i_pim_rdata    = 32'd0;
        #12;
        checkOutput("reset");
        #11;
        i_rst_n = 1'b1;

        applyStimulus(3'b000, 4'b0010, 13'd12, 32'h1000_0000, -1, 0, 0);
        waitIdle();
        applyStimulus(3'b001, 4'b0000, 13'd8, 32'h2000_0000, -1, 0, 0);
        waitIdle();
        applyStimulus(3'b000, 4'b0011, 13'd12, 32'h2400_0010, 1, 3, 0);
        waitIdle();
        applyStimulus(3'b001, 4'b0110, 13'd12, 32'h2800_0020, 1, 2, 0);
        waitIdle();
        applyStimulus(3'b000, 4'b0100, 13'd3, 32'h2C00_0000, -1, 0, 0);
        waitIdle();

        applyStimulus(3'b010, 4'b0001, 13'd16, 32'h3000_0000, -1, 0, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            check("reserved_busy", {31'd0, o_dma_busy}, 32'd0);
        end

        applyStimulus(3'b000, 4'b0101, 13'd16, 32'h3400_0000, -1, 0, 0);
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge i_clk);
            found = o_pim_valid && o_pim_we && (o_pim_addr == 11'd1);
        end
        check("reset_window_found", {31'd0, found}, 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        checkOutput("midreset");
        exp_q.delete();
        wait_q.delete();
        busy_cnt    = 0;
        cur_wait    = -1;
        rd_pending  = 0;
        pim_pending = 0;
        hold_valid  = 0;
        #4;
        i_rst_n = 1'b1;
        applyStimulus(3'b000, 4'b0101, 13'd16, 32'h3400_0000, -1, 0, 0);
        waitIdle();

        applyStimulus(3'b000, 4'b1001, 13'd8, 32'hFFFF_FFFC, -1, 0, 0);
        pulseEnable(3'b001, 13'd40);
        waitIdle();
        applyStimulus(3'b001, 4'b1010, 13'd12, 32'hFFFF_FFFB, 0, 2, 0);
        pulseEnable(3'b000, 13'd4);
        waitIdle();

        for (int t = 0; t < 30; t++) begin
            int          r;
            logic [2:0]  f3;
            logic [31:0] base;
            r    = int'($urandom_range(0, 9));
            f3   = (r == 0) ? 3'($urandom_range(2, 7)) : ((r % 2 == 1) ? 3'b001 : 3'b000);
            base = (r == 5) ? 32'hFFFF_FFF0 : $urandom;
            applyStimulus(f3, 4'($urandom), 13'($urandom_range(0, 48)), base, -1, 0, 1);
            waitIdle();
        end

        repeat (3) @(negedge i_clk);
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
